convex_pt_feeder: RTL and testbench

//  Host-side partner of the convex-hull engine. Buffers (X,Y) points from an upstream producer in a FIFO.

---
 rtl/convex_pt_feeder_pkg.sv | 35 +++
 rtl/convex_pt_feeder_pt_fifo.sv | 64 ++++++
 rtl/convex_pt_feeder.sv | 115 +++++++++++
 tb/tb_convex_pt_feeder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/convex_pt_feeder_pkg.sv
// -----------------------------------------------------------------------------
// convex_pt_feeder_pkg
// Shared constants, the point-serialisation phase encoding and the nibble
// selector used by the hull-engine point feeder.
// No ports (package).
// -----------------------------------------------------------------------------
package convex_pt_feeder_pkg;

  localparam int COORD_W = 10;
  localparam int NIB_W   = 5;
  localparam int PT_W    = 2 * COORD_W;   // point stored as {X, Y}

  typedef enum logic [1:0] {
    PH_XHI = 2'd0,
    PH_XLO = 2'd1,
    PH_YHI = 2'd2,
    PH_YLO = 2'd3
  } phase_t;

  // Nibble sent to the engine for a given phase of point {X, Y}.
  function automatic logic [NIB_W-1:0] pt_nibble(input logic [PT_W-1:0] pt,
                                                 input phase_t ph);
    logic [NIB_W-1:0] nib;
    nib = '0;
    case (ph)
      PH_XHI: nib = pt[19:15];
      PH_XLO: nib = pt[14:10];
      PH_YHI: nib = pt[9:5];
      PH_YLO: nib = pt[4:0];
      default: nib = '0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/convex_pt_feeder_pt_fifo.sv
// -----------------------------------------------------------------------------
// pt_fifo
// Point FIFO for the feeder. Head entry is presented combinationally on
// o_head; a push into a full FIFO and a pop from an empty FIFO are ignored.
// Ports:
//   CLK, RST          clock, async active-high reset (empties the FIFO)
//   i_push / i_data   write request and data
//   i_pop             read request (advances head)
//   o_head            current head entry
//   o_full / o_empty  occupancy flags
// -----------------------------------------------------------------------------
module pt_fifo
  import convex_pt_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = PT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/convex_pt_feeder.sv
// -----------------------------------------------------------------------------
// convex_pt_feeder
// Host-side partner of the convex-hull engine. Buffers (X,Y) points, serialises
// each as four 5-bit nibbles (X hi, X lo, Y hi, Y lo) on READ_PT requests, and
// monitors the engine's dropped-point outputs.
// Ports:
//   CLK, RST                  clock, async active-high reset
//   IN_VALID/IN_READY/IN_X/Y  upstream point handshake
//   READ_PT / PT_XY           engine nibble request / registered nibble
//   DROP_V/DROP_X/DROP_Y      engine drop report
//   DROP_CNT                  saturating drop counter
//   LAST_DX/LAST_DY           most recently dropped point
//   UNDERRUN                  sticky: point requested with FIFO empty
// -----------------------------------------------------------------------------
module convex_pt_feeder
  import convex_pt_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [COORD_W-1:0] IN_X,
  input  logic [COORD_W-1:0] IN_Y,
  input  logic               READ_PT,
  output logic [NIB_W-1:0]   PT_XY,
  input  logic               DROP_V,
  input  logic [COORD_W-1:0] DROP_X,
  input  logic [COORD_W-1:0] DROP_Y,
  output logic [CNT_W-1:0]   DROP_CNT,
  output logic [COORD_W-1:0] LAST_DX,
  output logic [COORD_W-1:0] LAST_DY,
  output logic               UNDERRUN
);

  logic [PT_W-1:0]    w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  phase_t             r_phase;
  logic [PT_W-1:0]    r_cur;
  logic [NIB_W-1:0]   r_pt_xy;
  logic               r_underrun;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [COORD_W-1:0] r_last_dx;
  logic [COORD_W-1:0] r_last_dy;

  // Ready depends only on stored occupancy, never on READ_PT.
  assign IN_READY = !w_full;
  // A pop on an empty FIFO is discarded inside the FIFO (no bypass).
  assign w_pop    = READ_PT && (r_phase == PH_XHI);

  pt_fifo #(
    .DEPTH (DEPTH),
    .W     (PT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (IN_VALID),
    .i_data  ({IN_X, IN_Y}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Phase sequencer: the phase register is the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_phase    <= PH_XHI;
      r_cur      <= '0;
      r_pt_xy    <= '0;
      r_underrun <= 1'b0;
    end else if (READ_PT) begin
      case (r_phase)
        PH_XHI: begin
          if (!w_empty) begin
            r_cur   <= w_head;
            r_pt_xy <= pt_nibble(w_head, PH_XHI);
            r_phase <= PH_XLO;
          end else begin
            r_pt_xy    <= '0;
            r_underrun <= 1'b1;
          end
        end
        default: begin
          r_pt_xy <= pt_nibble(r_cur, r_phase);
          r_phase <= phase_t'(r_phase + 2'd1);
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drop_cnt <= '0;
      r_last_dx  <= '0;
      r_last_dy  <= '0;
    end else if (DROP_V) begin
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      r_last_dx <= DROP_X;
      r_last_dy <= DROP_Y;
    end
  end

  assign PT_XY    = r_pt_xy;
  assign UNDERRUN = r_underrun;
  assign DROP_CNT = r_drop_cnt;
  assign LAST_DX  = r_last_dx;
  assign LAST_DY  = r_last_dy;

endmodule

// File: tb/tb_convex_pt_feeder.sv
// -----------------------------------------------------------------------------
// tb_convex_pt_feeder
// Directed self-checking bench for convex_pt_feeder. Expected nibbles are
// queued when points are pushed and popped as the engine side reads them.
// -----------------------------------------------------------------------------
module tb_convex_pt_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [9:0] IN_X, IN_Y;
  logic       READ_PT;
  logic [4:0] PT_XY;
  logic       DROP_V;
  logic [9:0] DROP_X, DROP_Y;
  logic [7:0] DROP_CNT;
  logic [9:0] LAST_DX, LAST_DY;
  logic       UNDERRUN;

  convex_pt_feeder #(.DEPTH(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
    .READ_PT(READ_PT), .PT_XY(PT_XY),
    .DROP_V(DROP_V), .DROP_X(DROP_X), .DROP_Y(DROP_Y),
    .DROP_CNT(DROP_CNT), .LAST_DX(LAST_DX), .LAST_DY(LAST_DY),
    .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0] exp_q[$];
  int         m_cnt;
  int         m_phase;
  bit         m_under;
  int         m_dcnt;
  logic [9:0] m_dx, m_dy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN_VALID = 1'b0; READ_PT = 1'b0; DROP_V = 1'b0;
    IN_X = '0; IN_Y = '0; DROP_X = '0; DROP_Y = '0;
    exp_q.delete();
    m_cnt = 0; m_phase = 0; m_under = 0; m_dcnt = 0; m_dx = '0; m_dy = '0;
    #3;
    check("rst_pt_xy",    32'(PT_XY),    32'h0);
    check("rst_in_ready", 32'(IN_READY), 32'h1);
    check("rst_drop_cnt", 32'(DROP_CNT), 32'h0);
    check("rst_underrun", 32'(UNDERRUN), 32'h0);
    check("rst_last_dx",  32'(LAST_DX),  32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic push_pt(input logic [9:0] x, input logic [9:0] y);
    check("in_ready", 32'(IN_READY), 32'(m_cnt < 16));
    IN_VALID = 1'b1; IN_X = x; IN_Y = y;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    if (m_cnt < 16) begin
      m_cnt++;
      exp_q.push_back(x[9:5]);
      exp_q.push_back(x[4:0]);
      exp_q.push_back(y[9:5]);
      exp_q.push_back(y[4:0]);
    end
  endtask

  // One READ_PT cycle; READ_PT is left high so consecutive calls are gapless.
  task automatic read_cycle(input string tag);
    logic [4:0] e;
    if (m_phase == 0) begin
      if (m_cnt == 0) begin
        e = 5'h0;
        m_under = 1'b1;
      end else begin
        e = exp_q.pop_front();
        m_cnt--;
        m_phase = 1;
      end
    end else begin
      e = exp_q.pop_front();
      m_phase = (m_phase + 1) % 4;
    end
    READ_PT = 1'b1;
    @(posedge CLK); #1;
    check(tag, 32'(PT_XY), 32'(e));
    check({tag, "_underrun"}, 32'(UNDERRUN), 32'(m_under));
  endtask

  task automatic read_stop();
    READ_PT = 1'b0;
  endtask

  task automatic drop(input logic [9:0] x, input logic [9:0] y);
    DROP_V = 1'b1; DROP_X = x; DROP_Y = y;
    @(posedge CLK); #1;
    DROP_V = 1'b0;
    if (m_dcnt < 255) m_dcnt++;
    m_dx = x; m_dy = y;
  endtask

  initial begin
    RST = 1'b0;
    IN_VALID = 1'b0; READ_PT = 1'b0; DROP_V = 1'b0;
    IN_X = '0; IN_Y = '0; DROP_X = '0; DROP_Y = '0;
    @(posedge CLK); #1;
    do_reset();
    repeat (2) @(posedge CLK);
    #1;

    // Single point: 2A5/13C -> 15, 05, 09, 1C
    push_pt(10'h2A5, 10'h13C);
    check("t2_queued", 32'(exp_q[0]), 32'h15);
    for (int i = 0; i < 4; i++) read_cycle($sformatf("t2_nib%0d", i));
    read_stop();
    @(posedge CLK); #1;
    check("t2_hold", 32'(PT_XY), 32'h1C);

    // Back-to-back: 3 points, 12 gapless reads
    push_pt(10'h3FF, 10'h000);
    push_pt(10'h155, 10'h2AA);
    push_pt(10'h0C3, 10'h31E);
    for (int i = 0; i < 12; i++) read_cycle($sformatf("t3_nib%0d", i));
    read_stop();

    // Full: 16 pushes, 17th rejected, then drain all
    for (int i = 0; i < 16; i++) push_pt(10'(i * 37 + 5), 10'(1023 - i * 11));
    check("t4_full_ready", 32'(IN_READY), 32'h0);
    push_pt(10'h111, 10'h222);
    for (int i = 0; i < 64; i++) read_cycle($sformatf("t4_nib%0d", i));
    read_stop();
    check("t4_ready_after", 32'(IN_READY), 32'h1);

    // Underrun on empty FIFO, sticky, then normal point
    read_cycle("t5_empty");
    read_stop();
    @(posedge CLK); #1;
    check("t5_sticky", 32'(UNDERRUN), 32'h1);
    push_pt(10'h2C0, 10'h05A);
    for (int i = 0; i < 4; i++) read_cycle($sformatf("t5_nib%0d", i));
    read_stop();

    // Drops
    drop(10'h3FF, 10'h001);
    drop(10'h010, 10'h020);
    check("t6_cnt2",  32'(DROP_CNT), 32'h2);
    check("t6_dx",    32'(LAST_DX),  32'h010);
    check("t6_dy",    32'(LAST_DY),  32'h020);
    DROP_X = 10'h123; DROP_Y = 10'h321;
    @(posedge CLK); #1;
    check("t6_ignore_dx", 32'(LAST_DX),  32'h010);
    check("t6_ignore_cnt", 32'(DROP_CNT), 32'h2);
    for (int i = 0; i < 300; i++) drop(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    check("t6_sat",    32'(DROP_CNT), 32'(m_dcnt));
    check("t6_sat_ff", 32'(DROP_CNT), 32'hFF);
    check("t6_last_dx", 32'(LAST_DX), 32'(m_dx));
    check("t6_last_dy", 32'(LAST_DY), 32'(m_dy));

    // Reset mid-point: partial point and queued points discarded
    push_pt(10'h1E1, 10'h0F0);
    push_pt(10'h2D2, 10'h3C3);
    read_cycle("t7_pre0");
    read_cycle("t7_pre1");
    read_stop();
    do_reset();
    push_pt(10'h0AB, 10'h1CD);
    for (int i = 0; i < 4; i++) read_cycle($sformatf("t7_nib%0d", i));
    read_stop();
    read_cycle("t7_empty");
    read_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
